// File: rtl/inst_pkg.sv
// Purpose: shared types, field widths and the MIPS field-to-word encoder.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package inst_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int INDEX_W  = 26;
    localparam int INST_W   = 32;

    // Instruction format selector; FMT_RSVD field sets are dropped and flagged.
    typedef enum logic [1:0] {
        FMT_R    = 2'd0,
        FMT_I    = 2'd1,
        FMT_J    = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_t;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Every decoded field; each format uses only a subset.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    sa;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    immediate;
        logic [INDEX_W-1:0]  inst_index;
    } inst_fields_t;

    // Pack the fields relevant to the format into one instruction word.
    function automatic logic [INST_W-1:0] encode_inst(input fmt_t fmt, input inst_fields_t f);
        logic [INST_W-1:0] w;
        w = '0;
        case (fmt)
            FMT_R:   w = {f.opcode, f.rs, f.rt, f.rd, f.sa, f.funct};
            FMT_I:   w = {f.opcode, f.rs, f.rt, f.immediate};
            FMT_J:   w = {f.opcode, f.inst_index};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Purpose: synchronous DEPTH-entry FIFO for encoded instruction words.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic [W-1:0]     r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign empty     = (r_wptr == r_rptr);
    assign head      = r_mem[r_rptr[PTR_W-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointer update; a clear empties the FIFO regardless of push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= push_dat;
    end

endmodule

// File: rtl/inst_encoder.sv
// Purpose: encode MIPS field sets into words and write them to sequential imem addresses.
// Latency: accepted field set reaches mem_we/mem_wdata one cycle later at the earliest.
// Backpressure: in_ready drops when the FIFO is full; mem_ready low holds the current write.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                stop,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    sa,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    immediate,
    input  logic [INDEX_W-1:0]  inst_index,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INST_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    output logic [ADDR_W:0]     word_count,
    output logic                done,
    output logic                err_fmt,
    output logic                wrapped
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_count;
    logic               r_err_fmt;
    logic               r_wrapped;

    fmt_t               w_fmt;
    inst_fields_t       w_fields;
    logic [INST_W-1:0]  w_enc;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_start;
    logic               w_full;
    logic               w_empty;
    logic [INST_W-1:0]  w_head;
    logic               w_wr_done;

    assign w_fmt    = fmt_t'(fmt);
    assign w_fields = '{opcode:     opcode,
                        rs:         rs,
                        rt:         rt,
                        rd:         rd,
                        sa:         sa,
                        funct:      funct,
                        immediate:  immediate,
                        inst_index: inst_index};
    assign w_enc    = encode_inst(w_fmt, w_fields);

    // Input side: only RUN accepts, and only while there is room.
    assign w_in_ready = (r_state == ST_RUN) && !w_full;
    assign w_accept   = in_valid && w_in_ready;
    // Reserved-format field sets are consumed but produce no word.
    assign w_push     = w_accept && (w_fmt != FMT_RSVD);
    assign w_start    = (r_state == ST_IDLE) && start;
    // The write port presents the FIFO head whenever anything is buffered.
    assign w_wr_done  = !w_empty && mem_ready;

    inst_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (w_start),
        .push     (w_push),
        .push_dat (w_enc),
        .pop      (w_wr_done),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

    // Next-state: DRAIN waits for the FIFO to empty, which also means no write is pending.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)   w_state_nxt = ST_RUN;
            ST_RUN:   if (stop)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Address, word counter and sticky flags; a start re-arms all of them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_err_fmt <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (w_start) begin
            r_addr    <= base_addr;
            r_count   <= '0;
            r_err_fmt <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_accept && (w_fmt == FMT_RSVD)) r_err_fmt <= 1'b1;
            if (w_wr_done) begin
                r_addr <= r_addr + 1'b1;
                if (r_addr == {ADDR_W{1'b1}}) r_wrapped <= 1'b1;
                if (r_count != {(ADDR_W+1){1'b1}}) r_count <= r_count + 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign mem_we     = !w_empty;
    assign mem_addr   = r_addr;
    // Gate with empty so stale storage never shows on the bus when idle or after reset.
    assign mem_wdata  = w_empty ? '0 : w_head;
    assign word_count = r_count;
    // DRAIN with an empty FIFO is exactly the cycle before returning to IDLE.
    assign done       = (r_state == ST_DRAIN) && w_empty;
    assign err_fmt    = r_err_fmt;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    import inst_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;

    logic              clk        = 1'b0;
    logic              rstn       = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W-1:0] base_addr  = '0;
    logic              stop       = 1'b0;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic [1:0]        fmt        = '0;
    logic [5:0]        opcode     = '0;
    logic [4:0]        rs         = '0;
    logic [4:0]        rt         = '0;
    logic [4:0]        rd         = '0;
    logic [4:0]        sa         = '0;
    logic [5:0]        funct      = '0;
    logic [15:0]       immediate  = '0;
    logic [25:0]       inst_index = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready  = 1'b1;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              err_fmt;
    logic              wrapped;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct), .immediate(immediate),
        .inst_index(inst_index), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .word_count(word_count),
        .done(done), .err_fmt(err_fmt), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          rand_rdy = 1'b0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_dat[$];

    // Reference model state for the current session.
    logic [31:0]       exp_dat[$];
    int unsigned       m_base;
    bit                m_err;

    // Record every completed write and every done pulse.
    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_dat.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic MIPS encoding.
    function automatic int unsigned ref_word(input int unsigned f, input int unsigned op,
                                             input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d,
                                             input int unsigned fn, input int unsigned imm,
                                             input int unsigned idx);
        case (f)
            0: return op * (1 << 26) + a * (1 << 21) + b * (1 << 16) + c * (1 << 11) + d * (1 << 6) + fn;
            1: return op * (1 << 26) + a * (1 << 21) + b * (1 << 16) + imm;
            2: return op * (1 << 26) + idx;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic begin_session(input int unsigned base);
        base_addr = ADDR_W'(base);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_dat.delete();
        log_addr.delete();
        log_dat.delete();
        m_base = base;
        m_err = 1'b0;
        done_base = done_cnt;
    endtask

    task automatic send(input int unsigned f, input int unsigned op, input int unsigned a,
                        input int unsigned b, input int unsigned c, input int unsigned d,
                        input int unsigned fn, input int unsigned imm, input int unsigned idx);
        bit acc;
        acc = 1'b0;
        fmt = 2'(f); opcode = 6'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); sa = 5'(d);
        funct = 6'(fn); immediate = 16'(imm); inst_index = 26'(idx);
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            if (in_ready) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("accept_timeout", 64'(acc), 64'(1));
        if (acc) begin
            if (f == 3) m_err = 1'b1;
            else exp_dat.push_back(ref_word(f, op % 64, a % 32, b % 32, c % 32, d % 32,
                                            fn % 64, imm % 65536, idx % (1 << 26)));
        end
    endtask

    task automatic send_rand(input int unsigned f);
        send(f, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
             $urandom_range(0, 65535), $urandom & 32'h03FF_FFFF);
    endtask

    task automatic finish_session(input string tag);
        bit got;
        int n;
        int unsigned ea;
        got = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            if (done_cnt > done_base) got = 1'b1;
            else tick();
        end
        check({tag, "_done_timeout"}, 64'(got), 64'(1));
        tick(); tick(); tick();
        check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'(1));
        check({tag, "_nwrites"}, 64'(log_dat.size()), 64'(exp_dat.size()));
        n = (log_dat.size() < exp_dat.size()) ? log_dat.size() : exp_dat.size();
        for (int i = 0; i < n; i++) begin
            ea = (m_base + i) % (1 << ADDR_W);
            check({tag, "_addr"}, 64'(log_addr[i]), 64'(ea));
            check({tag, "_data"}, 64'(log_dat[i]), 64'(exp_dat[i]));
        end
        check({tag, "_word_count"}, 64'(word_count), 64'(exp_dat.size()));
        check({tag, "_err_fmt"}, 64'(err_fmt), 64'(m_err));
        check({tag, "_wrapped"}, 64'(wrapped),
              64'((m_base + exp_dat.size()) >= (1 << ADDR_W)));
        check({tag, "_idle_in_ready"}, 64'(in_ready), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'(0));
        check({tag, "_mem_we"},     64'(mem_we),     64'(0));
        check({tag, "_mem_addr"},   64'(mem_addr),   64'(0));
        check({tag, "_mem_wdata"},  64'(mem_wdata),  64'(0));
        check({tag, "_word_count"}, 64'(word_count), 64'(0));
        check({tag, "_done"},       64'(done),       64'(0));
        check({tag, "_err_fmt"},    64'(err_fmt),    64'(0));
        check({tag, "_wrapped"},    64'(wrapped),    64'(0));
    endtask

    initial begin
        logic [ADDR_W-1:0] hold_a;
        logic [31:0]       hold_d;
        int                nlog;

        // Reset values.
        tick(); tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        // Empty session: start -> in_ready next cycle; stop -> done next cycle, then idle.
        begin_session(32'h0040);
        check("start_in_ready", 64'(in_ready), 64'(1));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_done_pulse", 64'(done), 64'(1));
        check("stop_drain_in_ready", 64'(in_ready), 64'(0));
        tick();
        check("stop_done_low", 64'(done), 64'(0));

        // R-format encoding.
        begin_session(32'h0100);
        send(0, 0, 1, 2, 3, 0, 32'h20, $urandom_range(0, 65535), $urandom & 32'h03FF_FFFF);
        finish_session("rfmt");
        if (log_dat.size() > 0) check("rfmt_word", 64'(log_dat[0]), 64'h0022_1820);

        // I and J encoding at consecutive addresses.
        begin_session(32'h0200);
        send(1, 8, 0, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
             5, $urandom & 32'h03FF_FFFF);
        send(2, 2, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535), 32'h10);
        finish_session("ij");
        if (log_dat.size() > 1) begin
            check("ij_iword", 64'(log_dat[0]), 64'h2001_0005);
            check("ij_jword", 64'(log_dat[1]), 64'h0800_0010);
        end

        // Backpressure: four accepts fill the FIFO, the write is held stable.
        begin_session(32'h0300);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand($urandom_range(0, 2));
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_head_word", 64'(mem_wdata), 64'(exp_dat[0]));
        hold_a = mem_addr;
        hold_d = mem_wdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stable", {18'd0, hold_a, hold_d, mem_we}, {18'd0, mem_addr, mem_wdata, 1'b1});
            check("bp_still_full", 64'(in_ready), 64'(0));
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) send_rand($urandom_range(0, 2));
        finish_session("bp");

        // Reserved format between two valid words.
        begin_session(32'h0400);
        send_rand(0);
        send_rand(3);
        send_rand(1);
        finish_session("rsvd");

        // Random formats, gaps and write backpressure.
        begin_session($urandom_range(0, (1 << ADDR_W) - 64));
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_rand($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
        end
        finish_session("rand");
        rand_rdy = 1'b0;
        mem_ready = 1'b1;

        // Address wrap sets the sticky flag; next start clears it.
        begin_session((1 << ADDR_W) - 1);
        send_rand(0);
        send_rand(2);
        finish_session("wrap");
        if (log_addr.size() > 1) begin
            check("wrap_addr0", 64'(log_addr[0]), 64'h3FFF);
            check("wrap_addr1", 64'(log_addr[1]), 64'h0000);
        end
        begin_session(32'h0010);
        check("restart_wrapped", 64'(wrapped), 64'(0));
        check("restart_mem_addr", 64'(mem_addr), 64'h0010);
        finish_session("restart");

        // Reset with three words buffered.
        begin_session(32'h0500);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(1);
        check("pre_reset_we", 64'(mem_we), 64'(1));
        rstn = 1'b0;
        #2;
        check_all_zero("midreset");
        tick();
        rstn = 1'b1;
        mem_ready = 1'b1;
        nlog = log_dat.size();
        repeat (10) tick();
        check("post_reset_nwrites", 64'(log_dat.size() - nlog), 64'(0));
        check("post_reset_we", 64'(mem_we), 64'(0));
        check("post_reset_in_ready", 64'(in_ready), 64'(0));
        begin_session(32'h0600);
        send_rand(0);
        finish_session("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
